// File: rtl/nes_pkg.sv
// nes_pkg: shared constants for the NES pad poller (FSM encoding, button bit indices, default timing).
package nes_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LATCH  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CLK_HI = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int DEF_POLL_DIV     = 416667;
  localparam int DEF_LATCH_CYCLES = 300;
  localparam int DEF_HALF_CYCLES  = 150;
  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for one asynchronous input.
//   clk  : destination clock
//   rst  : synchronous active-high reset, loads RST_VAL into both flops
//   d    : asynchronous input
//   q    : synchronized output, two cycles behind d
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk) begin
    if (rst) begin
      m <= RST_VAL;
      q <= RST_VAL;
    end else begin
      m <= d;
      q <= m;
    end
  end
endmodule

// File: rtl/nes_pad_poller.sv
// nes_pad_poller: periodically latches and serially reads an NES pad, publishing active-high buttons.
//   clk_25mhz  : system clock
//   rst        : synchronous active-high reset
//   pad_data   : serial data from the pad, low = pressed, asynchronous
//   pad_latch  : parallel-load strobe to the pad
//   pad_clk    : shift clock to the pad (pad shifts on rising edge)
//   buttons    : button state, bit 0=A .. bit 7=Right
//   frame_done : one-cycle pulse when buttons was just updated
//   int_out    : one-cycle pulse when the new buttons differ from the previous value
module nes_pad_poller
  import nes_pkg::*;
#(
  parameter int POLL_DIV     = DEF_POLL_DIV,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
  parameter int HALF_CYCLES  = DEF_HALF_CYCLES
) (
  input  logic       clk_25mhz,
  input  logic       rst,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       frame_done,
  output logic       int_out
);
  localparam int PW = cnt_w(POLL_DIV);
  localparam int TW = cnt_w(LATCH_CYCLES > HALF_CYCLES ? LATCH_CYCLES : HALF_CYCLES);
  logic          data_s;
  logic          poll_tick;
  logic          t_end;
  logic [PW-1:0] poll_cnt;
  logic [TW-1:0] timer;
  logic [2:0]    state;
  logic [2:0]    nxt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  // An open line idles high, so resetting the synchronizer high avoids a fake press.
  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk_25mhz),
    .rst (rst),
    .d   (pad_data),
    .q   (data_s)
  );
  assign poll_tick = poll_cnt == PW'(POLL_DIV - 1);
  always_comb t_end = state == ST_LATCH ? timer == TW'(LATCH_CYCLES - 1)
                                        : timer == TW'(HALF_CYCLES - 1);
  // Ticks outside IDLE are dropped; unknown encodings recover to IDLE.
  always_comb begin
    nxt = state == ST_IDLE   ? (poll_tick ? ST_LATCH : ST_IDLE)
        : state == ST_DONE   ? ST_IDLE
        : state >  ST_DONE   ? ST_IDLE
        : !t_end             ? state
        : state == ST_LATCH  ? ST_SETTLE
        : state == ST_CLK_HI ? ST_SETTLE
        : bit_idx == 3'd7    ? ST_DONE
        :                      ST_CLK_HI;
  end
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      poll_cnt   <= '0;
      state      <= ST_IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      pad_latch  <= 1'b0;
      pad_clk    <= 1'b0;
      buttons    <= '0;
      frame_done <= 1'b0;
      int_out    <= 1'b0;
    end else begin
      poll_cnt <= poll_tick ? '0 : poll_cnt + PW'(1);
      state    <= nxt;
      timer    <= nxt != state ? '0 : timer + TW'(1);
      // Bit is sampled at the very end of the settle window, just before pad_clk rises.
      if (state == ST_SETTLE && t_end) begin
        shift[bit_idx] <= ~data_s;
        if (bit_idx != 3'd7) bit_idx <= bit_idx + 3'd1;
      end
      if (state == ST_DONE) begin
        bit_idx <= '0;
        buttons <= shift;
      end
      // Pad strobes follow the next state so they are clean flop outputs aligned with the state.
      pad_latch  <= nxt == ST_LATCH;
      pad_clk    <= nxt == ST_CLK_HI;
      frame_done <= state == ST_DONE;
      int_out    <= state == ST_DONE && shift != buttons;
    end
  end
endmodule

// File: tb/tb_nes_pad_poller.sv
// tb_nes_pad_poller: self-checking bench for nes_pad_poller with a behavioural 4021 pad model.
module tb_nes_pad_poller;
  import nes_pkg::*;
  typedef struct {
    logic [7:0] pad;
    logic [7:0] exp_btn;
    logic       exp_int;
  } vec_t;
  logic       clk_25mhz = 1'b0;
  logic       rst = 1'b1;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons;
  logic       frame_done;
  logic       int_out;
  logic [7:0] pad_state = 8'h00;
  logic [7:0] sr = 8'hFF;
  logic       pclk_q = 1'b0;
  logic       disc = 1'b0;
  logic       glitch_n = 1'b1;
  int         int_cnt = 0;
  int         checks = 0;
  int         failures = 0;
  nes_pad_poller #(.POLL_DIV(200), .LATCH_CYCLES(8), .HALF_CYCLES(4)) dut (
    .clk_25mhz  (clk_25mhz),
    .rst        (rst),
    .pad_data   (pad_data),
    .pad_latch  (pad_latch),
    .pad_clk    (pad_clk),
    .buttons    (buttons),
    .frame_done (frame_done),
    .int_out    (int_out)
  );
  always #20 clk_25mhz = ~clk_25mhz;
  // Pad model: parallel load while latched, shift towards bit 0 on each pad_clk rise.
  always @(posedge clk_25mhz) begin
    if (pad_latch) sr <= pad_state;
    else if (pad_clk && !pclk_q) sr <= {1'b0, sr[7:1]};
    pclk_q <= pad_clk;
  end
  assign pad_data = disc ? glitch_n : ~sr[0];
  always @(negedge clk_25mhz) if (int_out) int_cnt <= int_cnt + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic run_frame(input string tag, input logic [7:0] eb, input logic ei, input int el);
    int n, lat, rises, hi, run, badw;
    logic pq;
    n = 0;
    while (!pad_latch && n < 1000) begin
      @(negedge clk_25mhz);
      n++;
    end
    chk({tag, ".latch_delay"}, n, el);
    if (!pad_latch) return;
    n = 0; lat = 0; rises = 0; hi = 0; run = 0; badw = 0; pq = 1'b0;
    while (!frame_done && n < 200) begin
      if (pad_latch) lat++;
      if (pad_clk) begin
        hi++;
        run++;
        if (!pq) rises++;
      end else begin
        if (pq && run != 4) badw++;
        run = 0;
      end
      pq = pad_clk;
      @(negedge clk_25mhz);
      n++;
    end
    chk({tag, ".frame_len"}, n, 69);
    chk({tag, ".latch_width"}, lat, 8);
    chk({tag, ".clk_rises"}, rises, 7);
    chk({tag, ".clk_high_total"}, hi, 28);
    chk({tag, ".clk_pulse_width_bad"}, badw, 0);
    chk({tag, ".buttons"}, buttons, eb);
    chk({tag, ".int_out"}, int_out, ei);
    @(negedge clk_25mhz);
    chk({tag, ".frame_done_pulse"}, frame_done, 0);
    chk({tag, ".int_out_pulse"}, int_out, 0);
    chk({tag, ".buttons_hold"}, buttons, eb);
  endtask
  vec_t vecs[7];
  initial begin
    logic [7:0] prev, ps;
    int n, c0;
    vecs[0] = '{8'b0000_1001, 8'h09, 1'b1};
    vecs[1] = '{8'b0000_1001, 8'h09, 1'b0};
    vecs[2] = '{8'hA5, 8'hA5, 1'b1};
    vecs[3] = '{8'h5A, 8'h5A, 1'b1};
    vecs[4] = '{8'h5A, 8'h5A, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1};
    repeat (5) @(negedge clk_25mhz);
    chk("rst.pad_latch", pad_latch, 0);
    chk("rst.pad_clk", pad_clk, 0);
    chk("rst.buttons", buttons, 0);
    chk("rst.frame_done", frame_done, 0);
    chk("rst.int_out", int_out, 0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      pad_state = vecs[i].pad;
      run_frame($sformatf("vec%0d", i), vecs[i].exp_btn, vecs[i].exp_int, i == 0 ? 200 : 130);
    end
    pad_state = 8'h3C;
    run_frame("pre_rst", 8'h3C, 1'b1, 130);
    chk("pre_rst.right_bit", {31'd0, buttons[BTN_RIGHT]}, 0);
    chk("pre_rst.start_bit", {31'd0, buttons[BTN_START]}, 1);
    n = 0;
    while (!pad_latch && n < 1000) begin
      @(negedge clk_25mhz);
      n++;
    end
    chk("midrst.latch_delay", n, 130);
    repeat (30) @(negedge clk_25mhz);
    chk("midrst.in_clk_hi", pad_clk, 1);
    rst = 1'b1;
    @(negedge clk_25mhz);
    chk("midrst.pad_clk", pad_clk, 0);
    chk("midrst.pad_latch", pad_latch, 0);
    chk("midrst.buttons", buttons, 0);
    chk("midrst.frame_done", frame_done, 0);
    chk("midrst.int_out", int_out, 0);
    rst = 1'b0;
    run_frame("post_rst", 8'h3C, 1'b1, 200);
    prev = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      ps = 8'($urandom);
      if ($urandom_range(3) == 0) ps = prev;
      pad_state = ps;
      run_frame($sformatf("rnd%0d", i), ps, ps != prev, 130);
      prev = ps;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk_25mhz);
    rst = 1'b0;
    disc = 1'b1;
    pad_state = 8'hFF;
    c0 = int_cnt;
    repeat (50) @(negedge clk_25mhz);
    glitch_n = 1'b0;
    repeat (3) @(negedge clk_25mhz);
    glitch_n = 1'b1;
    run_frame("disc0", 8'h00, 1'b0, 147);
    run_frame("disc1", 8'h00, 1'b0, 130);
    chk("disc.int_count", int_cnt - c0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
